// File: rtl/fetch_line_pkg.sv
// Shared sizing defaults and helpers for the instruction-line fetch stage.
package fetch_line_pkg;

    localparam int XLEN_DEF     = 32;
    localparam int BUS_WID_DEF  = 64;
    localparam int FIFO_DEP_DEF = 2;

    // Width of a counter that must hold values 0..dep inclusive.
    function automatic int cnt_width(input int dep);
        return $clog2(dep) + 1;
    endfunction

endpackage

// File: rtl/line_fifo.sv
// Synchronous FIFO of {err,data} fetch lines with single-cycle flush.
module line_fifo
    import fetch_line_pkg::*;
#(
    parameter int W   = BUS_WID_DEF + 1,
    parameter int DEP = FIFO_DEP_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    input  logic                       flush,
    output logic                       empty,
    output logic [cnt_width(DEP)-1:0]  count,
    output logic [W-1:0]               head
);
    localparam int AW = $clog2(DEP);
    localparam int CW = cnt_width(DEP);
    localparam logic [CW-1:0] FULL = CW'(DEP);

    logic [W-1:0]  mem_q [DEP];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign do_pop  = pop & (count_q != '0) & ~flush;
    assign do_push = push & ~flush & ((count_q != FULL) | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

    assign head  = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign count = count_q;

    // The upstream credit scheme must never offer a line to a full FIFO.
    assert property (@(posedge clk) disable iff (!rst)
        !(push && !flush && !do_pop && (count_q == FULL)));

endmodule

// File: rtl/fetch_line.sv
// fetch_line: issues line-aligned instruction reads, drops stale responses after a jump,
// and presents one buffered line per cycle. Optional macro FETCH_ERR_HALT_EN halts fetch on error.
module fetch_line
    import fetch_line_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int BUS_WID  = BUS_WID_DEF,
    parameter int FIFO_DEP = FIFO_DEP_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               jump_vld,
    input  logic [XLEN-1:0]    jump_pc,
    input  logic               buffer_free,
    output logic               imem_req,
    output logic [XLEN-1:0]    imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvld,
    input  logic [BUS_WID-1:0] imem_rdata,
    input  logic               imem_rerr,
    output logic               line_vld,
    output logic [BUS_WID-1:0] line_data,
    output logic               line_err
);
    localparam int LB   = BUS_WID / 8;
    localparam int OFFW = $clog2(LB);
    localparam int CW   = cnt_width(FIFO_DEP);
    localparam logic [CW:0] DEP_LIM = (CW+1)'(FIFO_DEP);

    logic [XLEN-1:0]    fetch_addr_q, fetch_addr_d;
    logic [CW-1:0]      outstanding_q, outstanding_d;
    logic [CW-1:0]      drop_cnt_q, drop_cnt_d;
    logic               active_q, active_d;
    logic               line_vld_q, line_vld_d;
    logic [BUS_WID-1:0] line_data_q, line_data_d;
    logic               line_err_q, line_err_d;
    logic [CW-1:0]      fifo_count;
    logic               fifo_empty;
    logic [BUS_WID:0]   fifo_head;
    logic [CW:0]        in_use;
    logic               halted, accept, push, pop;
    logic [OFFW-1:0]    unused_jump_lsb;

    assign unused_jump_lsb = jump_pc[OFFW-1:0];

`ifdef FETCH_ERR_HALT_EN
    logic halt_q, halt_d;

    always_comb begin
        halt_d = halt_q;
        if (jump_vld)               halt_d = 1'b0;
        else if (push && imem_rerr) halt_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) halt_q <= 1'b0;
        else      halt_q <= halt_d;
    end

    assign halted = halt_q;
`else
    assign halted = 1'b0;
`endif

    // Credit covers both requests in flight and lines parked in the FIFO.
    assign in_use    = {1'b0, outstanding_q} + {1'b0, fifo_count};
    assign imem_req  = active_q & ~jump_vld & ~halted & (in_use < DEP_LIM);
    assign imem_addr = fetch_addr_q;
    assign accept    = imem_req & imem_gnt;
    assign push      = imem_rvld & (drop_cnt_q == '0) & ~jump_vld;
    assign pop       = ~jump_vld & ~fifo_empty & buffer_free;

    line_fifo #(
        .W   (BUS_WID + 1),
        .DEP (FIFO_DEP)
    ) u_line_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   ({imem_rerr, imem_rdata}),
        .pop   (pop),
        .flush (jump_vld),
        .empty (fifo_empty),
        .count (fifo_count),
        .head  (fifo_head)
    );

    always_comb begin
        active_d      = 1'b1;
        fetch_addr_d  = fetch_addr_q;
        outstanding_d = outstanding_q + CW'(accept) - CW'(imem_rvld);
        drop_cnt_d    = drop_cnt_q;
        line_vld_d    = pop;
        line_data_d   = line_data_q;
        line_err_d    = line_err_q;

        if (jump_vld)    fetch_addr_d = {jump_pc[XLEN-1:OFFW], {OFFW{1'b0}}};
        else if (accept) fetch_addr_d = fetch_addr_q + XLEN'(LB);

        // Everything still in flight at a jump belongs to the abandoned stream.
        if (jump_vld)                          drop_cnt_d = outstanding_q - CW'(imem_rvld);
        else if (imem_rvld && drop_cnt_q != '0) drop_cnt_d = drop_cnt_q - CW'(1);

        if (pop) begin
            line_data_d = fifo_head[BUS_WID-1:0];
            line_err_d  = fifo_head[BUS_WID];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active_q      <= 1'b0;
            fetch_addr_q  <= '0;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            line_vld_q    <= 1'b0;
            line_data_q   <= '0;
            line_err_q    <= 1'b0;
        end else begin
            active_q      <= active_d;
            fetch_addr_q  <= fetch_addr_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            line_vld_q    <= line_vld_d;
            line_data_q   <= line_data_d;
            line_err_q    <= line_err_d;
        end
    end

    assign line_vld  = line_vld_q;
    assign line_data = line_data_q;
    assign line_err  = line_err_q;

endmodule

// File: tb/tb_fetch_line.sv
// Randomized scoreboard bench for fetch_line: memory model plus expected line stream per jump target.
module tb_fetch_line;
    localparam int XLEN     = 32;
    localparam int BUS_WID  = 64;
    localparam int FIFO_DEP = 2;
    localparam int LB       = BUS_WID / 8;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               jump_vld = 1'b0;
    logic [XLEN-1:0]    jump_pc = '0;
    logic               buffer_free = 1'b0;
    logic               imem_req;
    logic [XLEN-1:0]    imem_addr;
    logic               imem_gnt = 1'b0;
    logic               imem_rvld = 1'b0;
    logic [BUS_WID-1:0] imem_rdata = '0;
    logic               imem_rerr = 1'b0;
    logic               line_vld;
    logic [BUS_WID-1:0] line_data;
    logic               line_err;

    always #5 clk = ~clk;

    fetch_line #(
        .XLEN     (XLEN),
        .BUS_WID  (BUS_WID),
        .FIFO_DEP (FIFO_DEP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .jump_vld    (jump_vld),
        .jump_pc     (jump_pc),
        .buffer_free (buffer_free),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvld   (imem_rvld),
        .imem_rdata  (imem_rdata),
        .imem_rerr   (imem_rerr),
        .line_vld    (line_vld),
        .line_data   (line_data),
        .line_err    (line_err)
    );

    typedef struct {
        logic [31:0] a;
        int          due;
    } req_t;

    req_t        pend[$];
    logic [31:0] exp_q[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          last_due = 0;
    int          p_jump = 0, p_free = 100, p_gnt = 100, lat_min = 1, lat_max = 1;
    bit          force_j = 1'b0;
    logic [31:0] force_pc = '0;
    bit          force_coin = 1'b0;
    int          coin_cnt = 0;
    logic [31:0] exp_req_addr = '0;
    logic [31:0] prev_acc = '0;
    bit          saw_wrap = 1'b0;

    bit          prev_jump = 1'b0;
    bit          first_pending = 1'b0;
    int          first_vld_cyc = -1;
    logic [31:0] first_addr = '0;
    logic [31:0] mon_addr;
    int          n_lines = 0;
    int          n_err_lines = 0;
`ifdef FETCH_ERR_HALT_EN
    bit          err_delivered = 1'b0;
`endif

    function automatic logic [31:0] line_of(input logic [31:0] pc);
        return pc & ~32'(LB - 1);
    endfunction

    function automatic logic [63:0] data_of(input logic [31:0] a);
        return {a ^ 32'h5A5A_C3C3, a * 32'h9E37_79B1};
    endfunction

    function automatic logic err_of(input logic [31:0] a);
        return a[9:0] == 10'h208;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic refill(input logic [31:0] start);
        exp_q.delete();
        for (int i = 0; i < 512; i++) exp_q.push_back(start + 32'(i * LB));
    endtask

    // Monitor: each delivered line must be the next one of the stream begun at the last jump.
    always @(negedge clk) begin
        if (!rst) begin
            refill(32'h0);
            prev_jump     = 1'b0;
            first_pending = 1'b0;
`ifdef FETCH_ERR_HALT_EN
            err_delivered = 1'b0;
`endif
        end else begin
            if (line_vld) begin
                n_lines++;
                check("vld_after_jump", 64'(prev_jump), 64'(0));
                if (exp_q.size() == 0) begin
                    check("line_expected", 64'(0), 64'(1));
                end else begin
                    mon_addr = exp_q.pop_front();
                    check("line_data", line_data, data_of(mon_addr));
                    check("line_err", 64'(line_err), 64'(err_of(mon_addr)));
                    if (first_pending) begin
                        first_pending = 1'b0;
                        first_vld_cyc = cyc;
                        first_addr    = mon_addr;
                    end
                end
                if (line_err) begin
                    n_err_lines++;
`ifdef FETCH_ERR_HALT_EN
                    err_delivered = 1'b1;
`endif
                end
            end
`ifdef FETCH_ERR_HALT_EN
            if (err_delivered && !jump_vld) check("halt_req", 64'(imem_req), 64'(0));
`endif
            if (jump_vld) begin
                refill(line_of(jump_pc));
                first_pending = 1'b1;
`ifdef FETCH_ERR_HALT_EN
                err_delivered = 1'b0;
`endif
            end
            prev_jump = jump_vld;
        end
    end

    task automatic step();
        req_t r;
        int   due;
        @(posedge clk);
        #1;
        cyc++;
        imem_rvld  = 1'b0;
        imem_rerr  = 1'b0;
        imem_rdata = {$urandom, $urandom};
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            r          = pend.pop_front();
            imem_rvld  = 1'b1;
            imem_rdata = data_of(r.a);
            imem_rerr  = err_of(r.a);
        end
        buffer_free = int'($urandom_range(99)) < p_free;
        imem_gnt    = int'($urandom_range(99)) < p_gnt;
        jump_vld    = 1'b0;
        jump_pc     = $urandom & 32'hFFFF_FFFE;
        if (force_j) begin
            jump_vld = 1'b1;
            jump_pc  = force_pc;
            force_j  = 1'b0;
        end else if (force_coin && imem_rvld && line_vld) begin
            jump_vld = 1'b1;
            coin_cnt++;
        end else if (int'($urandom_range(99)) < p_jump) begin
            jump_vld = 1'b1;
        end
        @(negedge clk);
        if (imem_req && imem_gnt) begin
            check("req_addr", 64'(imem_addr), 64'(exp_req_addr));
            if (prev_acc == 32'hFFFF_FFF8 && imem_addr == 32'h0) saw_wrap = 1'b1;
            prev_acc = imem_addr;
            due = cyc + int'($urandom_range(lat_max, lat_min));
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pend.push_back('{imem_addr, due});
            exp_req_addr = exp_req_addr + 32'(LB);
        end
        check("in_flight_limit", 64'(pend.size() <= FIFO_DEP), 64'(1));
        if (jump_vld) begin
            check("req_on_jump", 64'(imem_req), 64'(0));
            exp_req_addr = line_of(jump_pc);
        end
    endtask

    task automatic do_reset();
        #2;
        rst         = 1'b0;
        jump_vld    = 1'b0;
        imem_rvld   = 1'b0;
        imem_gnt    = 1'b0;
        buffer_free = 1'b0;
        #1;
        check("rst_imem_req", 64'(imem_req), 64'(0));
        check("rst_imem_addr", 64'(imem_addr), 64'(0));
        check("rst_line_vld", 64'(line_vld), 64'(0));
        check("rst_line_data", line_data, 64'(0));
        check("rst_line_err", 64'(line_err), 64'(0));
        pend.delete();
        last_due     = cyc;
        exp_req_addr = 32'h0;
        prev_acc     = 32'h0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
    endtask

    initial begin
        int base;
        int jcyc;
        bit got;

        do_reset();

        // Stream from 0x106 with single-cycle memory and a free buffer.
        p_jump = 0; p_free = 100; p_gnt = 100; lat_min = 1; lat_max = 1;
        force_j = 1'b1; force_pc = 32'h106;
        step();
        jcyc = cyc;
        base = n_lines;
        repeat (30) step();
        check("first_line_latency", 64'(first_vld_cyc - jcyc), 64'(4));
        check("first_line_addr", 64'(first_addr), 64'(32'h100));
        check("stream_rate", 64'((n_lines - base) >= 15), 64'(1));

        // Backpressure: buffer held busy long enough to exhaust credit.
        p_free = 0; lat_max = 3;
        repeat (10) step();
        check("bp_req_blocked", 64'(imem_req), 64'(0));
        p_free = 100;
        repeat (20) step();

        // Jump with two requests outstanding on a slow memory.
        lat_min = 3; lat_max = 3;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            if (pend.size() == 2) got = 1'b1;
        end
        check("two_outstanding", 64'(got), 64'(1));
        force_j = 1'b1; force_pc = 32'h400;
        step();
        repeat (25) step();
        check("jump_first_addr", 64'(first_addr), 64'(32'h400));

        // Jumps landing on cycles with both a response and an output line.
        lat_min = 1; lat_max = 2;
        force_coin = 1'b1; coin_cnt = 0;
        repeat (60) step();
        force_coin = 1'b0;
        check("coincident_jump_seen", 64'(coin_cnt > 0), 64'(1));

        // Error on line 0x208, then a jump to 0x300.
        lat_min = 1; lat_max = 1;
        force_j = 1'b1; force_pc = 32'h200;
        step();
        base = n_err_lines;
        repeat (30) step();
        check("err_line_count", 64'(n_err_lines - base), 64'(1));
`ifdef FETCH_ERR_HALT_EN
        check("halted_req", 64'(imem_req), 64'(0));
`endif
        force_j = 1'b1; force_pc = 32'h300;
        step();
        repeat (20) step();
        check("resume_addr", 64'(first_addr), 64'(32'h300));

        // Address wrap at the top of the space.
        saw_wrap = 1'b0;
        force_j = 1'b1; force_pc = 32'hFFFF_FFF8;
        step();
        repeat (10) step();
        check("addr_wrap", 64'(saw_wrap), 64'(1));

        // Random traffic with an asynchronous reset in the middle of it.
        p_jump = 6; p_free = 70; p_gnt = 70; lat_min = 1; lat_max = 4;
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) do_reset();
            step();
        end

        // Drain with everything open.
        p_jump = 0; p_free = 100; p_gnt = 100;
        force_j = 1'b1; force_pc = 32'h1000;
        step();
        base = n_lines;
        repeat (40) step();
        check("drain_progress", 64'((n_lines - base) > 0), 64'(1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
